// File: rtl/bus_host_bridge.sv
// Single-outstanding peripheral bus initiator: command in, one-cycle bus request, response or timeout out.
// Every output comes from a flop; an rvalid seen outside WAIT is reported as a stray pulse.
module bus_host_bridge #(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [AddressWidth-1:0] cmd_addr_i,
  input  logic                    cmd_we_i,
  input  logic [DataWidth/8-1:0]  cmd_be_i,
  input  logic [DataWidth-1:0]    cmd_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DataWidth-1:0]    rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic                    bus_req_o,
  output logic [AddressWidth-1:0] bus_addr_o,
  output logic                    bus_we_o,
  output logic [DataWidth/8-1:0]  bus_be_o,
  output logic [DataWidth-1:0]    bus_wdata_o,
  input  logic                    bus_rvalid_i,
  input  logic [DataWidth-1:0]    bus_rdata_i,
  input  logic                    bus_err_i,
  output logic                    stray_rvalid_o
);

  if (DataWidth != 32) begin : g_bad_data_width
    $error("bus_host_bridge: DataWidth must be 32");
  end
  if (TimeoutCycles < 1 || TimeoutCycles > 255) begin : g_bad_timeout
    $error("bus_host_bridge: TimeoutCycles must be within 1..255");
  end

  localparam logic [7:0] CntLast = 8'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DataWidth/8-1:0]  be_q, be_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic [DataWidth-1:0]    rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    timeout_q, timeout_d;
  logic                    stray_q, stray_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    // Any rvalid not answering our request, including one in the REQ cycle itself.
    stray_d   = bus_rvalid_i && (state_q != WAIT);

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          we_d    = cmd_we_i;
          be_d    = cmd_be_i;
          wdata_d = cmd_wdata_i;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        // rvalid takes priority over a timeout expiring in the same cycle.
        if (bus_rvalid_i) begin
          rdata_d   = we_q ? '0 : bus_rdata_i;
          err_d     = bus_err_i;
          timeout_d = 1'b0;
          state_d   = RESP;
        end else if (cnt_q == CntLast) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      stray_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      stray_q   <= stray_d;
    end
  end

  assign cmd_ready_o    = (state_q == IDLE);
  assign bus_req_o      = (state_q == REQ);
  assign rsp_valid_o    = (state_q == RESP);
  assign bus_addr_o     = addr_q;
  assign bus_we_o       = we_q;
  assign bus_be_o       = be_q;
  assign bus_wdata_o    = wdata_q;
  assign rsp_rdata_o    = rdata_q;
  assign rsp_err_o      = err_q;
  assign rsp_timeout_o  = timeout_q;
  assign stray_rvalid_o = stray_q;

endmodule

// File: doc/bus_host_bridge.md
Name: bus_host_bridge

Overview:
- Single-outstanding bus initiator for the peripheral request/rvalid bus. Drives the peripheral bus on behalf of a command/response valid-ready interface.
- Issues one-cycle requests and captures the response returned on the cycle after the request (rdata/err qualified by rvalid).
- Converts a missing response into a timeout error.
- Sits between a test/debug or DMA-style command source and simple peripherals such as the counter/timer block.

Parameters:
- DataWidth, 32, bus data width; must be 32 (init assertion).
- AddressWidth, 32, bus address width.
- TimeoutCycles, 16, cycles spent in WAIT without rvalid before a timeout response; legal range 1..255.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_addr_i  in  AddressWidth  target address
- cmd_we_i  in  1  1=write, 0=read
- cmd_be_i  in  DataWidth/8  byte enables
- cmd_wdata_i  in  DataWidth  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid & ready
- rsp_rdata_o  out  DataWidth  read data (0 on write or timeout)
- rsp_err_o  out  1  bus error or timeout
- rsp_timeout_o  out  1  response produced by timeout
- bus_req_o  out  1  bus request, one-cycle pulse
- bus_addr_o  out  AddressWidth  bus address
- bus_we_o  out  1  bus write enable
- bus_be_o  out  DataWidth/8  bus byte enables
- bus_wdata_o  out  DataWidth  bus write data
- bus_rvalid_i  in  1  response valid from peripheral
- bus_rdata_i  in  DataWidth  peripheral read data
- bus_err_i  in  1  peripheral error, qualified by rvalid
- stray_rvalid_o  out  1  one-cycle pulse: rvalid seen outside WAIT

Behaviour:
- Reset values:
  - State = IDLE; cmd_ready_o = 1.
  - All other outputs = 0: rsp_valid_o, rsp_*, bus_*, stray_rvalid_o.
  - Timeout counter = 0.
- All outputs are registered or decoded directly from the state register. There is no combinational path from any input to any output.
- FSM states and transitions:
  - IDLE: cmd_ready_o=1. On cmd_valid_i, capture addr/we/be/wdata into the bus_* output registers and go to REQ.
  - REQ: bus_req_o=1 for exactly this cycle. Next state is WAIT; clear the timeout counter.
  - WAIT:
    - If bus_rvalid_i: capture the response and go to RESP.
      - rsp_rdata_o = we ? 0 : bus_rdata_i.
      - rsp_err_o = bus_err_i; rsp_timeout_o = 0.
    - Else if counter == TimeoutCycles-1: go to RESP with rdata=0, err=1, timeout=1.
    - Else increment the counter.
  - RESP: rsp_valid_o=1, with data held stable. On rsp_ready_i go to IDLE.
- Latency:
  - Accept at cycle T → bus_req_o at T+1.
  - Peripheral rvalid at T+2 → rsp_valid_o at T+3.
  - Next accept no earlier than the cycle after the response handshake. Minimum 4 cycles per transaction with rsp_ready_i held high.
- Bus fields:
  - bus_addr/we/be/wdata stay stable from REQ until the next accept.
  - They are not cleared on return to IDLE.
- Only one request is ever outstanding. bus_req_o is never asserted outside REQ.
- Stray rvalid:
  - bus_rvalid_i in IDLE, REQ or RESP is ignored for response purposes; stray_rvalid_o pulses the following cycle.
  - This includes an rvalid arriving in the same cycle as bus_req_o, and a late rvalid after a timeout.
- Timeout boundary:
  - rvalid in the same cycle the counter reaches TimeoutCycles-1 wins: a normal response is returned.
  - With TimeoutCycles=1, a response must arrive on the first WAIT cycle.
- Response backpressure: rsp_ready_i low holds RESP indefinitely. No new command is accepted and no bus activity occurs.
- Reset mid-transaction: asynchronous return to reset values. An in-flight response is dropped; a later rvalid after reset is flagged as stray.

Test Plan:
- Read counter:
  - Stimulus: cmd addr=0x40000, we=0; peripheral returns rdata=0x0000_0123, err=0 on the cycle after req.
  - Required: bus_req_o is a single pulse at T+1; rsp_valid_o at T+3 with rdata=0x123, err=0, timeout=0.
- Byte write:
  - Stimulus: addr=0x40000, we=1, be=4'b0001, wdata=0xAABBCCDD; peripheral rvalid with err=0.
  - Required: bus_be_o=0x1 and bus_wdata_o=0xAABBCCDD during req; response rdata=0, err=0.
- Bad address:
  - Stimulus: read addr=0x40004; peripheral rvalid with err=1.
  - Required: rsp_err_o=1, rsp_timeout_o=0.
- Timeout:
  - Stimulus: TimeoutCycles=16; no rvalid after req.
  - Required: rsp_valid_o with err=1, timeout=1, rdata=0 exactly 17 cycles after bus_req_o. A late rvalid 3 cycles later pulses stray_rvalid_o and produces no response.
- Backpressure and back-to-back:
  - Stimulus: rsp_ready_i held low for 5 cycles while cmd_valid_i is held high.
  - Required: cmd_ready_o=0 and bus_req_o=0 throughout; the second request issues 2 cycles after the rsp handshake (ready seen in IDLE the cycle after the handshake).
- Async reset in WAIT:
  - Stimulus: assert rst_ni low for 1 cycle.
  - Required: all outputs return to reset values immediately; cmd_ready_o=1 after release; the next read completes normally.
